// File: rtl/packet_deserializer.sv
// Receive-side packet deserializer: hunts for a sync word in the recovered bit
// stream, shifts in one MSB-first packet and offers it on a valid/ready handshake.
module packet_deserializer #(
  parameter int                   PACKET_SIZE = 32,
  parameter int                   SYNC_SIZE   = 8,
  parameter logic [SYNC_SIZE-1:0] SYNC_WORD   = 8'hA7,
  parameter int                   GAP_TIMEOUT = 64
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   bit_in,
  input  logic                   bit_valid,
  input  logic                   packet_ready,
  output logic [PACKET_SIZE-1:0] packet_out,
  output logic                   packet_valid,
  output logic                   sync_locked,
  output logic                   overrun,
  output logic                   frame_abort
);

  // state   | meaning
  // HUNT    | shifting bits through the sync register looking for SYNC_WORD
  // COLLECT | locked; shifting payload bits into the packet register
  typedef enum logic {HUNT, COLLECT} state_t;

  localparam int CW      = $clog2(PACKET_SIZE + 1);
  localparam int GW      = (GAP_TIMEOUT > 0) ? $clog2(GAP_TIMEOUT + 1) : 1;
  localparam int SHW     = (SYNC_SIZE > 1) ? SYNC_SIZE - 1 : 1;
  localparam logic [CW-1:0] LAST_BIT  = CW'(PACKET_SIZE - 1);
  localparam logic [GW-1:0] GAP_LIMIT = GW'(GAP_TIMEOUT);

  state_t                 state;
  logic [SHW-1:0]         sync_hist;
  logic [PACKET_SIZE-2:0] pkt_hist;
  logic [CW-1:0]          bit_count;
  logic [GW-1:0]          gap_count;

  logic [SYNC_SIZE-1:0]   sync_next;
  logic [PACKET_SIZE-1:0] pkt_next;
  logic                   timeout_hit;

  // Only the older SYNC_SIZE-1 (PACKET_SIZE-1) bits are stored; the newest bit
  // is appended combinationally so a match/completion happens on its own edge.
  assign sync_next   = SYNC_SIZE'({sync_hist, bit_in});
  assign pkt_next    = {pkt_hist, bit_in};
  assign timeout_hit = (GAP_TIMEOUT != 0) && (gap_count == GAP_LIMIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= HUNT;
      sync_hist    <= '0;
      pkt_hist     <= '0;
      bit_count    <= '0;
      gap_count    <= '0;
      packet_out   <= '0;
      packet_valid <= 1'b0;
      sync_locked  <= 1'b0;
      overrun      <= 1'b0;
      frame_abort  <= 1'b0;
    end else begin
      overrun     <= 1'b0;
      frame_abort <= 1'b0;
      if (packet_valid && packet_ready) packet_valid <= 1'b0;

      case (state)
        HUNT: begin
          if (bit_valid) begin
            sync_hist <= sync_next[SHW-1:0];
            if (sync_next == SYNC_WORD) begin
              state       <= COLLECT;
              sync_locked <= 1'b1;
              bit_count   <= '0;
              gap_count   <= '0;
            end
          end
        end

        COLLECT: begin
          // A stalled frame is abandoned even if a strobe arrives on this edge.
          if (timeout_hit) begin
            state       <= HUNT;
            sync_locked <= 1'b0;
            sync_hist   <= '0;
            bit_count   <= '0;
            gap_count   <= '0;
            frame_abort <= 1'b1;
          end else if (bit_valid) begin
            pkt_hist  <= pkt_next[PACKET_SIZE-2:0];
            gap_count <= '0;
            if (bit_count == LAST_BIT) begin
              state       <= HUNT;
              sync_locked <= 1'b0;
              sync_hist   <= '0;
              bit_count   <= '0;
              if (!packet_valid || packet_ready) begin
                packet_out   <= pkt_next;
                packet_valid <= 1'b1;
              end else begin
                overrun <= 1'b1;
              end
            end else begin
              bit_count <= bit_count + 1'b1;
            end
          end else begin
            gap_count <= gap_count + 1'b1;
          end
        end

        default: state <= HUNT;
      endcase
    end
  end

endmodule

// File: tb/tb_packet_deserializer.sv
// Directed bench for packet_deserializer: table-driven frames plus hand-written
// overrun, accept-on-completion, timeout and reset sequences.
module tb_packet_deserializer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       bit_in;
  logic       bit_valid;
  logic       ready;
  logic [7:0] packet_out;
  logic       packet_valid;
  logic       sync_locked;
  logic       overrun;
  logic       frame_abort;

  int errors = 0;
  int checks = 0;
  int ovr_cnt = 0;
  int abort_cnt = 0;

  logic       s1_lock, s1_valid, s2_valid;
  logic [7:0] s1_out, s2_out;

  packet_deserializer #(
    .PACKET_SIZE(8), .SYNC_SIZE(8), .SYNC_WORD(8'hA7), .GAP_TIMEOUT(16)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bit_in(bit_in), .bit_valid(bit_valid),
    .packet_ready(ready), .packet_out(packet_out), .packet_valid(packet_valid),
    .sync_locked(sync_locked), .overrun(overrun), .frame_abort(frame_abort)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (overrun === 1'b1) ovr_cnt++;
    if (frame_abort === 1'b1) abort_cnt++;
  end

  typedef struct {
    logic [15:0] pre;
    int          pre_len;
    logic [7:0]  payload;
    logic        rdy;
    logic [7:0]  exp_out;
    logic        exp_v2;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One strobe every 4 cycles; samples outputs 1 and 2 cycles after the strobe edge.
  task automatic send_bit(input logic b, input logic pulse);
    @(negedge clk);
    bit_in = b; bit_valid = 1'b1;
    if (pulse) ready = 1'b1;
    @(negedge clk);
    bit_valid = 1'b0; bit_in = 1'b0;
    if (pulse) ready = 1'b0;
    s1_lock = sync_locked; s1_valid = packet_valid; s1_out = packet_out;
    @(negedge clk);
    s2_valid = packet_valid; s2_out = packet_out;
    @(negedge clk);
  endtask

  task automatic send_frame(input logic [15:0] pre, input int len,
                            input logic [7:0] payload, input logic pulse_last);
    for (int i = 0; i < len; i++) begin
      send_bit(pre[len-1-i], 1'b0);
      if (i == len - 2) chk("lock_early", {31'd0, s1_lock}, 32'd0);
      if (i == len - 1) chk("lock_after_sync", {31'd0, s1_lock}, 32'd1);
    end
    for (int i = 7; i >= 0; i--) begin
      send_bit(payload[i], (i == 0) ? pulse_last : 1'b0);
      if (i == 1) chk("lock_mid_payload", {31'd0, s1_lock}, 32'd1);
      if (i == 0) chk("lock_after_packet", {31'd0, s1_lock}, 32'd0);
    end
  endtask

  task automatic clear_valid(input logic rdy_after);
    @(negedge clk); ready = 1'b1;
    @(negedge clk); ready = rdy_after;
  endtask

  vec_t vecs[3];
  int   ovr0, abort0;

  initial begin
    vecs[0] = '{pre: 16'h00A7, pre_len: 8,  payload: 8'hC3, rdy: 1'b0, exp_out: 8'hC3, exp_v2: 1'b1};
    vecs[1] = '{pre: 16'h00A7, pre_len: 8,  payload: 8'hC3, rdy: 1'b1, exp_out: 8'hC3, exp_v2: 1'b0};
    vecs[2] = '{pre: 16'h00A7, pre_len: 12, payload: 8'hA7, rdy: 1'b0, exp_out: 8'hA7, exp_v2: 1'b1};

    rst_n = 1'b0; bit_in = 1'b0; bit_valid = 1'b0; ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_out",   {24'd0, packet_out}, 32'd0);
    chk("rst_valid", {31'd0, packet_valid}, 32'd0);
    chk("rst_lock",  {31'd0, sync_locked}, 32'd0);
    chk("rst_ovr",   {31'd0, overrun}, 32'd0);
    chk("rst_abort", {31'd0, frame_abort}, 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Table: single frames, valid cleared first, ready held per vector
    for (int v = 0; v < 3; v++) begin
      clear_valid(vecs[v].rdy);
      ovr0 = ovr_cnt;
      send_frame(vecs[v].pre, vecs[v].pre_len, vecs[v].payload, 1'b0);
      chk("vec_out",      {24'd0, s1_out}, {24'd0, vecs[v].exp_out});
      chk("vec_valid",    {31'd0, s1_valid}, 32'd1);
      chk("vec_valid_n1", {31'd0, s2_valid}, {31'd0, vecs[v].exp_v2});
      chk("vec_out_n1",   {24'd0, s2_out}, {24'd0, vecs[v].exp_out});
      chk("vec_no_ovr",   ovr_cnt, ovr0);
    end

    // Trailing 0xFF after an 0xA7 payload must not relock
    ovr0 = ovr_cnt;
    for (int i = 0; i < 8; i++) begin
      send_bit(1'b1, 1'b0);
      chk("ff_no_relock", {31'd0, s1_lock}, 32'd0);
    end
    chk("ff_keep_out", {24'd0, packet_out}, 32'hA7);
    chk("ff_no_ovr", ovr_cnt, ovr0);

    // Back-to-back frames with ready low: second is dropped
    clear_valid(1'b0);
    send_frame(16'h00A7, 8, 8'h5A, 1'b0);
    chk("b2b_first", {24'd0, s1_out}, 32'h5A);
    ovr0 = ovr_cnt;
    send_frame(16'h00A7, 8, 8'h3C, 1'b0);
    chk("b2b_ovr",   ovr_cnt, ovr0 + 1);
    chk("b2b_keep",  {24'd0, s2_out}, 32'h5A);
    chk("b2b_valid", {31'd0, s2_valid}, 32'd1);

    // Completion in the same cycle the held packet is accepted
    ovr0 = ovr_cnt;
    send_frame(16'h00A7, 8, 8'h3C, 1'b1);
    chk("acc_out",    {24'd0, s1_out}, 32'h3C);
    chk("acc_valid",  {31'd0, s1_valid}, 32'd1);
    chk("acc_valid2", {31'd0, s2_valid}, 32'd1);
    chk("acc_no_ovr", ovr_cnt, ovr0);

    // Gap timeout mid-packet
    abort0 = abort_cnt;
    for (int i = 7; i >= 0; i--) begin
      logic [7:0] sw;
      sw = 8'hA7;
      send_bit(sw[i], 1'b0);
    end
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    repeat (14) @(negedge clk);
    chk("to_still_locked", {31'd0, sync_locked}, 32'd1);
    chk("to_no_early",     abort_cnt, abort0);
    repeat (10) @(negedge clk);
    chk("to_abort_once", abort_cnt, abort0 + 1);
    chk("to_unlocked",   {31'd0, sync_locked}, 32'd0);
    chk("to_valid_kept", {31'd0, packet_valid}, 32'd1);
    chk("to_out_kept",   {24'd0, packet_out}, 32'h3C);

    clear_valid(1'b0);
    send_frame(16'h00A7, 8, 8'h96, 1'b0);
    chk("post_to_out", {24'd0, s1_out}, 32'h96);

    // Reset mid-packet
    for (int i = 7; i >= 0; i--) begin
      logic [7:0] sw;
      sw = 8'hA7;
      send_bit(sw[i], 1'b0);
    end
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out",   {24'd0, packet_out}, 32'd0);
    chk("mid_rst_valid", {31'd0, packet_valid}, 32'd0);
    chk("mid_rst_lock",  {31'd0, sync_locked}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    send_frame(16'h00A7, 8, 8'h81, 1'b0);
    chk("post_rst_out", {24'd0, s1_out}, 32'h81);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/packet_deserializer.md
Name: packet_deserializer

Overview:
- Receive-side counterpart of the transmitter's packet serializer. Sits after bit recovery in the BPSK receiver.
- Hunts the recovered bit stream for a sync word, then shifts in one PACKET_SIZE-bit packet, MSB first, one bit per bit_valid strobe.
- Presents each completed packet on a valid/ready handshake to the downstream consumer.
- Flags overruns and aborts stalled frames.

Parameters:
- PACKET_SIZE, 32, payload bits per packet, received MSB first; minimum 2.
- SYNC_SIZE, 8, sync word length in bits; minimum 1.
- SYNC_WORD, 8'hA7, sync pattern, compared MSB-first against the most recent SYNC_SIZE bits.
- GAP_TIMEOUT, 64, maximum clk cycles between bit_valid strobes during COLLECT; 0 disables the timeout.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- bit_in  input  1  recovered data bit; sampled only when bit_valid=1.
- bit_valid  input  1  single-cycle strobe, one per received bit.
- packet_ready  input  1  consumer accepts packet_out this cycle.
- packet_out  output  PACKET_SIZE  last completed packet; first-received bit is at PACKET_SIZE-1.
- packet_valid  output  1  packet_out holds an unconsumed packet.
- sync_locked  output  1  high while in COLLECT.
- overrun  output  1  one-cycle pulse: a packet completed but was dropped.
- frame_abort  output  1  one-cycle pulse: GAP_TIMEOUT expired mid-packet.

Behaviour:
- Reset (async assert, sync-safe release): state=HUNT; sync shift register, packet shift register, bit counter and gap counter=0; packet_out=0; packet_valid, sync_locked, overrun, frame_abort=0.
- HUNT state:
  - On each bit_valid, shift bit_in into the SYNC_SIZE-bit sync register (LSB in).
  - If the updated value equals SYNC_WORD, move to COLLECT on that same edge; bit_count=0, gap counter=0.
  - A partial match is never detected; fewer than SYNC_SIZE bits since entering HUNT can match only if the register zeros complete the pattern.
- COLLECT state:
  - The first bit_valid after lock is packet bit PACKET_SIZE-1.
  - Each bit_valid shifts bit_in into the packet register and increments bit_count; bit_count width is clog2(PACKET_SIZE+1).
  - Non-strobe cycles increment the gap counter; any strobe clears it.
  - On the edge sampling bit number PACKET_SIZE, go to HUNT and clear the sync register, so payload bits cannot form a false sync.
  - On that same edge, perform the completion action below.
- Completion action:
  - If packet_valid=0, or packet_valid=1 and packet_ready=1 in the same cycle: load packet_out with the full packet and set packet_valid=1, visible the cycle after the last bit.
  - Otherwise keep the old packet_out and packet_valid, drop the new packet, and pulse overrun for 1 cycle.
- Handshake:
  - packet_valid falls on the edge after any cycle with packet_valid=1 and packet_ready=1, unless a completion loads a new packet on that edge.
  - packet_ready while packet_valid=0 is ignored.
  - packet_out is stable while packet_valid=1.
- Timeout: if GAP_TIMEOUT>0 and the gap counter reaches GAP_TIMEOUT in COLLECT:
  - Return to HUNT, clear the sync register and bit_count, and pulse frame_abort for 1 cycle.
  - The partial packet is discarded; packet_out and packet_valid are unaffected.
- sync_locked is registered and equals (state==COLLECT).
- A bit_valid on the abort edge is ignored.
- Reset mid-packet discards all state immediately. There is no X-propagation from bit_in when bit_valid=0.

Test Plan:
- PACKET_SIZE=8, SYNC_WORD=8'hA7: send 1010_0111 then 1100_0011, with a strobe every 4 cycles and ready held 0 -> sync_locked rises after the 8th sync bit; packet_out=8'hC3 and packet_valid=1 the cycle after the last bit; sync_locked=0.
- Same packet with ready held 1 -> packet_valid high for exactly 1 cycle; packet_out stays 8'hC3.
- Two back-to-back frames (payloads 8'h5A, 8'h3C) with ready=0 throughout -> first packet retained (8'h5A), overrun pulses once at the second completion, packet_valid stays 1.
- Second frame completes in the exact cycle ready=1 accepts the first -> packet_out=8'h3C, packet_valid stays 1, no overrun.
- Noise 0000_1010 then 0111 (the sync spans the boundary) -> lock after the 12th bit. Payload 8'hA7 followed by 8'hFF -> 8'hA7 delivered and no relock from payload bits.
- GAP_TIMEOUT=16: lock, send 3 bits, then idle 16 cycles -> frame_abort pulses once, sync_locked=0, packet_valid unchanged. Assert rst_n=0 mid-packet -> all outputs 0 immediately.
